// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access : MEM stage of the 5-stage RV32I pipeline.
//
// The stage sits between the ex_mem and mem_wb registers. Loads and stores go
// out one byte at a time over an 8-bit memory-controller port, little-endian,
// to consecutive (wrapping) addresses. Non-memory ops pass straight through.
// While an access is in flight stall_req stays high, so ctrl freezes ex_mem
// and every mem_* input remains stable until the access has finished.
//
// Ports
//   clk, rst       : clock; synchronous active-high reset
//   mem_wd         : destination register from ex_mem
//   mem_wreg       : register-write enable from ex_mem
//   mem_wdata      : EX result (ALU value)
//   mem_op         : opcode (LOAD 7'b0000011, STORE 7'b0100011)
//   mem_funct3     : access size / signedness
//   mem_mem_addr   : effective address
//   mem_reg        : store data (rs2)
//   wb_wd/wb_wreg/wb_wdata : towards mem_wb
//   stall_req      : pipeline hold request towards ctrl
//   bus_req/bus_we/bus_addr/bus_dout : byte request towards memory controller
//   bus_din/bus_ready                : byte response; a beat completes on an
//                                      edge where bus_ready=1
// -----------------------------------------------------------------------------
module mem_access #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        mem_wd,
  input  logic              mem_wreg,
  input  logic [31:0]       mem_wdata,
  input  logic [6:0]        mem_op,
  input  logic [2:0]        mem_funct3,
  input  logic [31:0]       mem_mem_addr,
  input  logic [31:0]       mem_reg,
  output logic [4:0]        wb_wd,
  output logic              wb_wreg,
  output logic [31:0]       wb_wdata,
  output logic              stall_req,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_dout,
  input  logic [7:0]        bus_din,
  input  logic              bus_ready
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e      state_q;
  logic [1:0]  cnt_q;       // index of the byte currently on the bus
  logic [1:0]  last_q;      // nbytes-1: index of the final byte
  logic [31:0] data_q;      // assembled load data

  logic        is_load_s;
  logic        is_store_s;
  logic        legal_s;
  logic [1:0]  last_idx_s;

  // Extend the assembled load bytes to 32 bits according to funct3.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {{24{d[7]}}, d[7:0]};
      3'b001:  r = {{16{d[15]}}, d[15:0]};
      3'b100:  r = {24'h000000, d[7:0]};
      3'b101:  r = {16'h0000, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Decode op type and access size; anything outside the table is illegal.
  always_comb begin
    is_load_s  = (mem_op == OP_LOAD);
    is_store_s = (mem_op == OP_STORE);
    legal_s    = 1'b0;
    last_idx_s = 2'd0;
    case (mem_funct3)
      3'b000: begin legal_s = is_load_s | is_store_s; last_idx_s = 2'd0; end
      3'b001: begin legal_s = is_load_s | is_store_s; last_idx_s = 2'd1; end
      3'b010: begin legal_s = is_load_s | is_store_s; last_idx_s = 2'd3; end
      3'b100: begin legal_s = is_load_s;              last_idx_s = 2'd0; end
      3'b101: begin legal_s = is_load_s;              last_idx_s = 2'd1; end
      default: begin legal_s = 1'b0;                  last_idx_s = 2'd0; end
    endcase
  end

  // Access sequencer: IDLE -> ACCESS (one cycle per completed beat) -> DONE -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      last_q  <= 2'd0;
      data_q  <= 32'h0000_0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (legal_s) begin
            state_q <= ACCESS;
            cnt_q   <= 2'd0;
            last_q  <= last_idx_s;
            data_q  <= 32'h0000_0000;
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          // A stalled beat (bus_ready=0) leaves cnt, address and data untouched.
          if (bus_ready) begin
            if (is_load_s) begin
              data_q[{cnt_q, 3'b000} +: 8] <= bus_din;
            end else begin
              data_q <= data_q;
            end
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == last_q) begin
              state_q <= DONE;
            end else begin
              state_q <= ACCESS;
            end
          end else begin
            state_q <= ACCESS;
          end
        end
        // Unconditional return so the frozen instruction is never re-issued.
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stage outputs; IDLE pass-through must be visible in the same cycle.
  always_comb begin
    wb_wd     = 5'd0;
    wb_wreg   = 1'b0;
    wb_wdata  = 32'h0000_0000;
    stall_req = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_dout  = 8'h00;
    if (rst) begin
      wb_wreg = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          wb_wd    = mem_wd;
          wb_wdata = mem_wdata;
          if (legal_s) begin
            stall_req = 1'b1;
          end else if (is_load_s | is_store_s) begin
            wb_wreg = 1'b0;  // illegal size: suppress the write
          end else begin
            wb_wreg = mem_wreg;
          end
        end
        ACCESS: begin
          wb_wd     = mem_wd;
          wb_wdata  = mem_wdata;
          stall_req = 1'b1;
          bus_req   = 1'b1;
          bus_we    = is_store_s;
          bus_addr  = mem_mem_addr[ADDR_W-1:0] + ADDR_W'(cnt_q);
          bus_dout  = mem_reg[{cnt_q, 3'b000} +: 8];
        end
        DONE: begin
          wb_wd    = mem_wd;
          wb_wreg  = mem_wreg;
          if (is_load_s) begin
            wb_wdata = load_extend(mem_funct3, data_q);
          end else begin
            wb_wdata = mem_wdata;
          end
        end
        default: begin
          wb_wreg = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [6:0]  mem_op;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        stall_req;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din;
  logic        bus_ready;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_access #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_op(mem_op), .mem_funct3(mem_funct3), .mem_mem_addr(mem_mem_addr),
    .mem_reg(mem_reg),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .stall_req(stall_req),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_dout(bus_dout), .bus_din(bus_din), .bus_ready(bus_ready)
  );

  task automatic drive_nop();
    mem_op = OP_IMM; mem_funct3 = 3'b000; mem_wd = 5'd0; mem_wreg = 1'b0;
    mem_wdata = 32'h0; mem_mem_addr = 32'h0; mem_reg = 32'h0;
    bus_ready = 1'b0; bus_din = 8'h00;
  endtask

  // Runs one memory op from its IDLE cycle through DONE; expected result is
  // queued at issue and popped when the stage stops stalling.
  task automatic do_access(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2,
                           input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                           input logic [31:0] ld_bytes, input logic [31:0] exp_wdata,
                           input int nbytes, input bit toggle);
    int cycles, stalls, beat, buscyc, exp_bus;
    bit flag, done;
    logic [31:0] t, exp_v;
    exp_q.push_back(exp_wdata);
    mem_op = op; mem_funct3 = f3; mem_mem_addr = addr; mem_reg = rs2;
    mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
    bus_ready = 1'b0; bus_din = 8'h00;
    cycles = 0; stalls = 0; beat = 0; buscyc = 0; flag = 1'b1; done = 1'b0;
    exp_bus = toggle ? (2 * nbytes - 1) : nbytes;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      cycles++;
      if (bus_req) begin
        buscyc++;
        checks++;
        if (bus_addr !== addr + 32'(beat)) begin
          failures++;
          $display("FAIL %s bus_addr beat %0d: got %h expected %h", name, beat, bus_addr, addr + 32'(beat));
        end
        checks++;
        if (bus_we !== (op == OP_STORE)) begin
          failures++;
          $display("FAIL %s bus_we: got %b expected %b", name, bus_we, (op == OP_STORE));
        end
        if (op == OP_STORE) begin
          t = rs2 >> (8 * beat);
          checks++;
          if (bus_dout !== t[7:0]) begin
            failures++;
            $display("FAIL %s bus_dout beat %0d: got %h expected %h", name, beat, bus_dout, t[7:0]);
          end
        end
        t = ld_bytes >> (8 * beat);
        bus_din = t[7:0];
        bus_ready = toggle ? flag : 1'b1;
        flag = ~flag;
        if (bus_ready) beat++;
      end else begin
        bus_ready = 1'b0;
        bus_din = 8'h00;
      end
      if (stall_req) begin
        stalls++;
      end else begin
        done = 1'b1;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        checks++;
        if (wb_wdata !== exp_v) begin
          failures++;
          $display("FAIL %s wb_wdata: got %h expected %h", name, wb_wdata, exp_v);
        end
        checks++;
        if (wb_wreg !== wreg || wb_wd !== wd) begin
          failures++;
          $display("FAIL %s wb_wreg/wb_wd: got %b/%0d expected %b/%0d", name, wb_wreg, wb_wd, wreg, wd);
        end
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s timeout: got no DONE expected DONE within 40 cycles", name);
    end
    checks++;
    if (beat != nbytes || buscyc != exp_bus) begin
      failures++;
      $display("FAIL %s beats: got %0d/%0d expected %0d/%0d", name, beat, buscyc, nbytes, exp_bus);
    end
    checks++;
    if (stalls != exp_bus + 1 || cycles != exp_bus + 2) begin
      failures++;
      $display("FAIL %s latency: got stall=%0d total=%0d expected stall=%0d total=%0d",
               name, stalls, cycles, exp_bus + 1, exp_bus + 2);
    end
    @(posedge clk); #1;
    bus_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_op = OP_LOAD; mem_funct3 = 3'b010; mem_wd = 5'd9; mem_wreg = 1'b1;
    mem_wdata = 32'hCAFE_F00D; mem_mem_addr = 32'h100; mem_reg = 32'h5555_AAAA;
    bus_ready = 1'b1; bus_din = 8'h33;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({wb_wd, wb_wreg, wb_wdata, stall_req, bus_req, bus_we, bus_addr, bus_dout} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got wd=%0d wreg=%b wdata=%h stall=%b req=%b we=%b addr=%h dout=%h expected all 0",
               wb_wd, wb_wreg, wb_wdata, stall_req, bus_req, bus_we, bus_addr, bus_dout);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_nop();
  endtask

  task automatic test_passthrough();
    logic [31:0] v;
    mem_op = OP_ALU; mem_wd = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'h0000_1234;
    mem_funct3 = 3'b000; mem_mem_addr = 32'h100; mem_reg = 32'h0;
    @(negedge clk);
    checks++;
    if (wb_wdata !== 32'h1234 || wb_wd !== 5'd5 || wb_wreg !== 1'b1 || stall_req !== 1'b0 || bus_req !== 1'b0) begin
      failures++;
      $display("FAIL passthrough_add: got wdata=%h wd=%0d wreg=%b stall=%b req=%b expected 1234/5/1/0/0",
               wb_wdata, wb_wd, wb_wreg, stall_req, bus_req);
    end
    @(posedge clk); #1;
    v = $urandom;
    mem_op = OP_IMM; mem_wd = 5'd31; mem_wreg = 1'b0; mem_wdata = v; mem_funct3 = 3'b010;
    @(negedge clk);
    checks++;
    if (wb_wdata !== v || wb_wd !== 5'd31 || wb_wreg !== 1'b0 || stall_req !== 1'b0 || bus_req !== 1'b0) begin
      failures++;
      $display("FAIL passthrough_imm: got wdata=%h wd=%0d wreg=%b stall=%b req=%b expected %h/31/0/0/0",
               wb_wdata, wb_wd, wb_wreg, stall_req, bus_req, v);
    end
    @(posedge clk); #1;
    drive_nop();
  endtask

  task automatic test_loads();
    do_access("lw",  OP_LOAD, 3'b010, 32'h100, 32'h0, 5'd1, 1'b1, 32'h100, 32'h1234_5678, 32'h1234_5678, 4, 1'b0);
    do_access("lb",  OP_LOAD, 3'b000, 32'h20,  32'h0, 5'd2, 1'b1, 32'h20,  32'h0000_0080, 32'hFFFF_FF80, 1, 1'b0);
    do_access("lbu", OP_LOAD, 3'b100, 32'h20,  32'h0, 5'd3, 1'b1, 32'h20,  32'h0000_0080, 32'h0000_0080, 1, 1'b0);
    do_access("lh",  OP_LOAD, 3'b001, 32'h40,  32'h0, 5'd4, 1'b1, 32'h40,  32'h0000_8001, 32'hFFFF_8001, 2, 1'b0);
    do_access("lhu", OP_LOAD, 3'b101, 32'h40,  32'h0, 5'd6, 1'b1, 32'h40,  32'h0000_8001, 32'h0000_8001, 2, 1'b0);
    do_access("lw_misaligned", OP_LOAD, 3'b010, 32'h101, 32'h0, 5'd7, 1'b1, 32'h101, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4, 1'b0);
    do_access("lh_wrap", OP_LOAD, 3'b001, 32'hFFFF_FFFF, 32'h0, 5'd8, 1'b1, 32'h0, 32'h0000_7F22, 32'h0000_7F22, 2, 1'b0);
    drive_nop();
  endtask

  task automatic test_stores();
    do_access("sh_toggle", OP_STORE, 3'b001, 32'h3FF, 32'hAABB_CCDD, 5'd0, 1'b0, 32'h3FF, 32'h0, 32'h3FF, 2, 1'b1);
    do_access("sb", OP_STORE, 3'b000, 32'h10, 32'h1234_5699, 5'd0, 1'b0, 32'h10, 32'h0, 32'h10, 1, 1'b0);
    do_access("sw_toggle", OP_STORE, 3'b010, 32'h800, 32'h0102_0304, 5'd0, 1'b0, 32'h800, 32'h0, 32'h800, 4, 1'b1);
    drive_nop();
  endtask

  task automatic test_reset_abort();
    mem_op = OP_LOAD; mem_funct3 = 3'b010; mem_mem_addr = 32'h200; mem_reg = 32'h0;
    mem_wd = 5'd3; mem_wreg = 1'b1; mem_wdata = 32'h200;
    bus_ready = 1'b1; bus_din = 8'h11;
    @(posedge clk); #1;        // IDLE -> ACCESS
    @(posedge clk); #1;        // first beat completes
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h201) begin
      failures++;
      $display("FAIL abort_second_beat: got req=%b addr=%h expected 1/00000201", bus_req, bus_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({wb_wreg, stall_req, bus_req} !== 3'b000) begin
      failures++;
      $display("FAIL abort_in_reset: got wreg=%b stall=%b req=%b expected 0/0/0", wb_wreg, stall_req, bus_req);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_nop();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus_req !== 1'b0 || stall_req !== 1'b0 || wb_wreg !== 1'b0) begin
        failures++;
        $display("FAIL abort_after_%0d: got req=%b stall=%b wreg=%b expected 0/0/0", i, bus_req, stall_req, wb_wreg);
      end
      @(posedge clk); #1;
    end
    do_access("lw_after_abort", OP_LOAD, 3'b010, 32'h300, 32'h0, 5'd10, 1'b1, 32'h300, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 4, 1'b0);
    drive_nop();
  endtask

  task automatic test_illegal();
    logic [6:0] ops [2];
    logic [2:0] f3s [2];
    ops[0] = OP_LOAD;  f3s[0] = 3'b011;
    ops[1] = OP_STORE; f3s[1] = 3'b100;
    for (int k = 0; k < 2; k++) begin
      mem_op = ops[k]; mem_funct3 = f3s[k]; mem_wd = 5'd7; mem_wreg = 1'b1;
      mem_wdata = 32'h0000_ABCD + 32'(k); mem_mem_addr = 32'h500; mem_reg = 32'h1;
      bus_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b0 || stall_req !== 1'b0 || wb_wreg !== 1'b0 ||
            wb_wd !== 5'd7 || wb_wdata !== 32'h0000_ABCD + 32'(k)) begin
          failures++;
          $display("FAIL illegal_%0d_cyc%0d: got req=%b stall=%b wreg=%b wd=%0d wdata=%h expected 0/0/0/7/%h",
                   k, i, bus_req, stall_req, wb_wreg, wb_wd, wb_wdata, 32'h0000_ABCD + 32'(k));
        end
        @(posedge clk); #1;
      end
    end
    bus_ready = 1'b0;
    do_access("lw_after_illegal", OP_LOAD, 3'b010, 32'h600, 32'h0, 5'd11, 1'b1, 32'h600, 32'h0BAD_F00D, 32'h0BAD_F00D, 4, 1'b0);
    drive_nop();
  endtask

  task automatic test_back_to_back();
    do_access("b2b_sw", OP_STORE, 3'b010, 32'h700, 32'h8899_AABB, 5'd0, 1'b0, 32'h700, 32'h0, 32'h700, 4, 1'b0);
    do_access("b2b_lb", OP_LOAD, 3'b000, 32'h703, 32'h0, 5'd12, 1'b1, 32'h703, 32'h0000_007F, 32'h0000_007F, 1, 1'b0);
    do_access("b2b_lhu", OP_LOAD, 3'b101, 32'h704, 32'h0, 5'd13, 1'b1, 32'h704, 32'h0000_FEDC, 32'h0000_FEDC, 2, 1'b0);
    drive_nop();
    @(negedge clk);
    checks++;
    if (stall_req !== 1'b0 || bus_req !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: got stall=%b req=%b expected 0/0", stall_req, bus_req);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    drive_nop();
    rst = 1'b1;
    test_reset();
    test_passthrough();
    test_loads();
    test_stores();
    test_reset_abort();
    test_illegal();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
